uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 107 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller.
// Builds the start / data / optional parity / stop frame on TX_OUT. An
// external serializer supplies the data bits on ser_data and shifts while
// ser_en is high. The serializer also flags the last data bit on ser_done.
// Optional feature: define UART_TX_STOP2_EN to send a second stop bit.
//
// Handshake: a frame is accepted when Data_Valid is 1 at a CLK edge with
// Busy 0. Data_Valid is a one-cycle strobe with no ready-style back-pressure.
// A strobe seen while Busy is 1 is dropped without effect, because the
// serializer uses the same acceptance condition for its own load.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5
`else
        S_STOP   = 3'd4
`endif
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   busy_q;
    logic   par_bit_q;   // XOR of the accepted data bits
    logic   par_en_q;
    logic   par_typ_q;
    logic   accept;

    // A frame is taken only from IDLE, so strobes during a frame are ignored
    assign accept = (state_q == S_IDLE) && Data_Valid;

    // State, busy flag and the parity settings captured at acceptance
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            if (accept) begin
                par_bit_q <= ^P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    // Next-state logic; ser_done only matters while in DATA
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Data_Valid) state_d = S_START;
            S_START:  state_d = S_DATA;
            S_DATA:   if (ser_done) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: state_d = S_STOP;
`ifdef UART_TX_STOP2_EN
            S_STOP:   state_d = S_STOP2;
            S_STOP2:  state_d = S_IDLE;
`else
            S_STOP:   state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Line mux selected by state alone, so Data_Valid never reaches TX_OUT
    always_comb begin
        TX_OUT = 1'b1;
        ser_en = 1'b0;
        case (state_q)
            S_START:  TX_OUT = 1'b0;
            S_DATA: begin
                TX_OUT = ser_data;
                ser_en = 1'b1;
            end
            S_PARITY: TX_OUT = par_bit_q ^ par_typ_q;
            default:  TX_OUT = 1'b1;
        endcase
    end

    assign Busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed table vectors plus randomized frames for
// uart_tx_ctrl. A small serializer model drives ser_data/ser_done. Expected
// line/Busy/ser_en triples are built from the frame rules into exp_q.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          ser_done;
    logic          ser_data;
    logic          ser_en;
    logic          TX_OUT;
    logic          Busy;
    logic [2:0]    state_dbg;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- serializer model ----------------
    logic [DW-1:0] sh = '0;
    int unsigned   cnt = 0;
    logic          done_noise = 1'b0;

    always @(posedge CLK) begin
        if (!RST) begin
            cnt <= 0;
        end else if (Data_Valid && !Busy) begin
            sh  <= P_DATA;
            cnt <= 0;
        end else if (ser_en) begin
            sh  <= sh >> 1;
            cnt <= cnt + 1;
        end
    end

    assign ser_data = sh[0];
    // Outside DATA ser_done carries random noise the controller must ignore
    assign ser_done = ser_en ? (cnt == DW - 1) : done_noise;

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];   // {TX_OUT, Busy, ser_en} per cycle

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got tx/busy/ser_en=%b expected %b", name, act, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s)
    function automatic void push_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
        exp_q.push_back(3'b010);
        for (int i = 0; i < DW; i++) exp_q.push_back({d[i], 2'b11});
        if (pe) exp_q.push_back({(^d) ^ pt, 2'b10});
        for (int s = 0; s < NSTOP; s++) exp_q.push_back(3'b110);
    endfunction

    // Called at a negedge with exp_q loaded; returns at a negedge in IDLE
    task automatic run_frame(input string name, input logic [DW-1:0] d, input bit pe,
                             input bit pt, input int dv_idx, input bit noise);
        int i;
        logic [2:0] e;
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        Data_Valid = 1'b1;
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            done_noise = 1'b0;
            if (noise) begin
                P_DATA = DW'($urandom);
                PAR_EN = 1'($urandom_range(0, 1));
                PAR_TYP = 1'($urandom_range(0, 1));
                Data_Valid = ($urandom_range(0, 3) == 0);
                done_noise = 1'($urandom_range(0, 1));
            end
            if (i == dv_idx) begin
                Data_Valid = 1'b1;
                P_DATA = '1;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s bit%0d", name, i), {TX_OUT, Busy, ser_en}, e);
            i++;
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        done_noise = 1'b0;
        chk($sformatf("%s idle", name), {TX_OUT, Busy, ser_en}, 3'b100);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string         name;
        logic [DW-1:0] data;
        bit            pe;
        bit            pt;
        logic [15:0]   bits;   // expected line, time order from bit len-1 down
        int            len;    // cycles with a single stop bit
        int            dv_idx; // cycle index of a stray strobe, -1 for none
    } vec_t;

    vec_t tbl[5];

    task automatic push_table(input vec_t v);
        logic [15:0] b;
        b = v.bits;
        for (int i = 0; i < v.len; i++)
            exp_q.push_back({b[v.len-1-i], 1'b1, (i >= 1 && i <= DW) ? 1'b1 : 1'b0});
        if (NSTOP == 2) exp_q.push_back(3'b110);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tbl[0] = '{"a5_even", 8'hA5, 1'b1, 1'b0, 16'b01010010101, 11, -1};
        tbl[1] = '{"a5_odd",  8'hA5, 1'b1, 1'b1, 16'b01010010111, 11, -1};
        tbl[2] = '{"zero_np", 8'h00, 1'b0, 1'b0, 16'b0000000001,  10, -1};
        tbl[3] = '{"3c_strb", 8'h3C, 1'b1, 1'b0, 16'b00011110001, 11,  4};
        tbl[4] = '{"81_np",   8'h81, 1'b0, 1'b0, 16'b0100000011,  10, -1};

        // Reset, with a strobe that must be discarded
        @(negedge CLK);
        Data_Valid = 1'b1;
        P_DATA = 8'h5A;
        @(negedge CLK);
        chk("reset outputs", {TX_OUT, Busy, ser_en}, 3'b100);
        chk("reset state", state_dbg, 3'd0);
        RST = 1'b1;
        Data_Valid = 1'b0;
        @(negedge CLK);
        chk("post reset idle", {TX_OUT, Busy, ser_en}, 3'b100);

        // Table frames (last entry is reserved for the post-reset frame)
        for (int k = 0; k < 4; k++) begin
            push_table(tbl[k]);
            run_frame(tbl[k].name, tbl[k].data, tbl[k].pe, tbl[k].pt, tbl[k].dv_idx, 1'b0);
        end

        // Reset during the 5th data cycle, with a coincident strobe
        push_frame(8'hC3, 1'b1, 1'b0);
        P_DATA = 8'hC3;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            logic [2:0] e;
            @(negedge CLK);
            Data_Valid = 1'b0;
            e = exp_q.pop_front();
            chk($sformatf("pre_rst bit%0d", i), {TX_OUT, Busy, ser_en}, e);
        end
        exp_q.delete();
        RST = 1'b0;
        Data_Valid = 1'b1;
        P_DATA = 8'hFF;
        @(negedge CLK);
        chk("rst abort", {TX_OUT, Busy, ser_en}, 3'b100);
        RST = 1'b1;
        Data_Valid = 1'b0;
        @(negedge CLK);
        chk("rst stays idle", {TX_OUT, Busy, ser_en}, 3'b100);
        push_table(tbl[4]);
        run_frame(tbl[4].name, tbl[4].data, tbl[4].pe, tbl[4].pt, tbl[4].dv_idx, 1'b0);

        // 0x55 without parity, then back-to-back frames on the first IDLE cycle
        push_frame(8'h55, 1'b0, 1'b0);
        run_frame("55_np", 8'h55, 1'b0, 1'b0, -1, 1'b0);
        push_frame(8'h55, 1'b1, 1'b1);
        run_frame("55_odd", 8'h55, 1'b1, 1'b1, -1, 1'b0);

        // Randomized frames with input noise during the frame
        for (int r = 0; r < 40; r++) begin
            logic [DW-1:0] d;
            bit pe;
            bit pt;
            d = DW'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            push_frame(d, pe, pt);
            run_frame($sformatf("rand%0d", r), d, pe, pt, -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
